// File: rtl/rubiks_polibot_pkg.sv
// Shared definitions for the Rubik's Polibot control unit: state codes and the
// move-word terminator.
package rubiks_polibot_pkg;

  typedef enum logic [4:0] {
    E_INICIAL           = 5'h00,
    E_PREPARA           = 5'h01,
    E_CAPTURA           = 5'h02,
    E_ESPERA_IMAGEM     = 5'h03,
    E_IDENTIFICA        = 5'h04,
    E_ESPERA_CORES      = 5'h05,
    E_ENVIA             = 5'h06,
    E_ESPERA_ENVIO      = 5'h07,
    E_DECIDE_FACE       = 5'h08,
    E_CONTA_FACE        = 5'h09,
    E_GIRO              = 5'h0A,
    E_ESPERA_GIRO       = 5'h0B,
    E_CONTA_GIRO        = 5'h0C,
    E_LE_GIRO           = 5'h0D,
    E_ZERA_LEITURA      = 5'h0E,
    E_OBTEM             = 5'h0F,
    E_ESPERA_MOVIMENTOS = 5'h10,
    E_ZERA_EXEC         = 5'h11,
    E_LE_EXEC           = 5'h12,
    E_VERIFICA          = 5'h13,
    E_EXECUTA           = 5'h14,
    E_ESPERA_EXEC       = 5'h15,
    E_CONTA_EXEC        = 5'h16,
    E_FIM               = 5'h17,
    E_ERRO              = 5'h1F
  } estado_t;

  // A solution ends at the first move word equal to this code.
  localparam logic [2:0] MOV_FIM = 3'b000;

  function automatic logic is_espera(input estado_t e);
    return (e == E_ESPERA_IMAGEM) || (e == E_ESPERA_CORES) ||
           (e == E_ESPERA_ENVIO) || (e == E_ESPERA_GIRO) ||
           (e == E_ESPERA_MOVIMENTOS) || (e == E_ESPERA_EXEC);
  endfunction

endpackage

// File: rtl/uc_timeout_counter.sv
// Saturating wait-time counter for the control unit; o_estouro rises once the
// count reaches LIMIT-1. Instantiated only when UC_TIMEOUT_EN is defined.
module uc_timeout_counter #(
  parameter int TW    = 26,
  parameter int LIMIT = 50_000_000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_estouro
);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != {TW{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_estouro = (r_cnt >= TW'(LIMIT - 1));

endmodule

// File: rtl/rubiks_polibot_uc.sv
// Moore control unit for the Rubik's Polibot datapath: scans six faces, fetches
// the solution and executes it. Optional wait-state watchdog: UC_TIMEOUT_EN.
import rubiks_polibot_pkg::*;

module rubiks_polibot_uc #(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int TW             = 26
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       imagem_recebida,
  input  logic       cores_identificadas,
  input  logic       cores_transmitidas,
  input  logic       movimentos_recebidos,
  input  logic       fim_movimento,
  input  logic       fim_face,
  input  logic       meio_face,
  input  logic       movimento_par,
  input  logic       fim_rom,
  output logic       zera_face,
  output logic       zera_movimento,
  output logic       conta_face,
  output logic       r_conta_movimento,
  output logic       captura_imagem,
  output logic       identificar_cores,
  output logic       enviar_cores,
  output logic       obter_movimentos,
  output logic       aciona_movimento,
  output logic       sel_serial1,
  output logic       sel_serial2,
  output logic       sel_ram_pixel,
  output logic       sel_cor,
  output logic       sel_movimento,
  output logic       pronto,
  output logic       erro,
  output logic [4:0] db_estado
);

  estado_t r_estado;
  estado_t w_proximo;
  logic    w_estouro;

`ifdef UC_TIMEOUT_EN
  logic w_limpa;
  logic w_conta;

  // Any state change restarts the wait budget.
  assign w_limpa = (w_proximo != r_estado);
  assign w_conta = is_espera(r_estado);

  uc_timeout_counter #(
    .TW    (TW),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clock   (clock),
    .i_reset   (reset),
    .i_clear   (w_limpa),
    .i_enable  (w_conta),
    .o_estouro (w_estouro)
  );
`else
  assign w_estouro = 1'b0;
  // The timeout parameters only take effect with the watchdog built in.
  if ((TW < 1) || (TIMEOUT_CYCLES < 1)) begin : g_cfg_invalid
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado <= E_INICIAL;
    end else begin
      r_estado <= w_proximo;
    end
  end

  // Done flags are levels sampled every cycle of a wait state, so a flag that
  // arrives in the first wait cycle is taken on the following edge.
  always_comb begin
    w_proximo = r_estado;
    case (r_estado)
      E_INICIAL:           w_proximo = iniciar ? E_PREPARA : E_INICIAL;
      E_PREPARA:           w_proximo = E_CAPTURA;
      E_CAPTURA:           w_proximo = E_ESPERA_IMAGEM;
      E_ESPERA_IMAGEM: begin
        if (imagem_recebida)  w_proximo = E_IDENTIFICA;
        else if (w_estouro)   w_proximo = E_ERRO;
      end
      E_IDENTIFICA:        w_proximo = E_ESPERA_CORES;
      E_ESPERA_CORES: begin
        if (cores_identificadas) w_proximo = E_ENVIA;
        else if (w_estouro)      w_proximo = E_ERRO;
      end
      E_ENVIA:             w_proximo = E_ESPERA_ENVIO;
      E_ESPERA_ENVIO: begin
        if (cores_transmitidas) w_proximo = E_DECIDE_FACE;
        else if (w_estouro)     w_proximo = E_ERRO;
      end
      E_DECIDE_FACE:       w_proximo = fim_face ? E_ZERA_LEITURA : E_CONTA_FACE;
      E_CONTA_FACE:        w_proximo = E_GIRO;
      E_GIRO:              w_proximo = E_ESPERA_GIRO;
      E_ESPERA_GIRO: begin
        if (fim_movimento)    w_proximo = E_CONTA_GIRO;
        else if (w_estouro)   w_proximo = E_ERRO;
      end
      E_CONTA_GIRO:        w_proximo = E_LE_GIRO;
      // Second-half faces are reached with a pair of moves: odd address means
      // the pair is not finished yet.
      E_LE_GIRO:           w_proximo = (meio_face && !movimento_par) ? E_GIRO : E_CAPTURA;
      E_ZERA_LEITURA:      w_proximo = E_OBTEM;
      E_OBTEM:             w_proximo = E_ESPERA_MOVIMENTOS;
      E_ESPERA_MOVIMENTOS: begin
        if (movimentos_recebidos) w_proximo = E_ZERA_EXEC;
        else if (w_estouro)       w_proximo = E_ERRO;
      end
      E_ZERA_EXEC:         w_proximo = E_LE_EXEC;
      E_LE_EXEC:           w_proximo = E_VERIFICA;
      E_VERIFICA:          w_proximo = fim_rom ? E_FIM : E_EXECUTA;
      E_EXECUTA:           w_proximo = E_ESPERA_EXEC;
      E_ESPERA_EXEC: begin
        if (fim_movimento)    w_proximo = E_CONTA_EXEC;
        else if (w_estouro)   w_proximo = E_ERRO;
      end
      E_CONTA_EXEC:        w_proximo = E_LE_EXEC;
      E_FIM:               w_proximo = E_INICIAL;
      E_ERRO:              w_proximo = E_ERRO;
      default:             w_proximo = E_INICIAL;
    endcase
  end

  always_comb begin
    zera_face         = 1'b0;
    zera_movimento    = 1'b0;
    conta_face        = 1'b0;
    r_conta_movimento = 1'b0;
    captura_imagem    = 1'b0;
    identificar_cores = 1'b0;
    enviar_cores      = 1'b0;
    obter_movimentos  = 1'b0;
    aciona_movimento  = 1'b0;
    sel_serial1       = 1'b0;
    sel_serial2       = 1'b0;
    sel_ram_pixel     = 1'b0;
    sel_cor           = 1'b0;
    sel_movimento     = 1'b0;
    pronto            = 1'b0;
    erro              = 1'b0;
    case (r_estado)
      E_PREPARA: begin
        zera_face      = 1'b1;
        zera_movimento = 1'b1;
      end
      E_CAPTURA: begin
        captura_imagem = 1'b1;
        sel_ram_pixel  = 1'b1;
      end
      E_ESPERA_IMAGEM:     sel_ram_pixel = 1'b1;
      E_IDENTIFICA: begin
        identificar_cores = 1'b1;
        sel_cor           = 1'b1;
      end
      E_ESPERA_CORES:      sel_cor = 1'b1;
      E_ENVIA: begin
        enviar_cores = 1'b1;
        sel_serial1  = 1'b1;
      end
      E_ESPERA_ENVIO:      sel_serial1 = 1'b1;
      E_CONTA_FACE:        conta_face = 1'b1;
      E_GIRO:              aciona_movimento = 1'b1;
      E_CONTA_GIRO:        r_conta_movimento = 1'b1;
      E_ZERA_LEITURA:      zera_movimento = 1'b1;
      E_OBTEM: begin
        obter_movimentos = 1'b1;
        sel_movimento    = 1'b1;
        sel_serial1      = 1'b1;
        sel_serial2      = 1'b1;
      end
      E_ESPERA_MOVIMENTOS: begin
        sel_movimento = 1'b1;
        sel_serial1   = 1'b1;
        sel_serial2   = 1'b1;
      end
      E_ZERA_EXEC:         zera_movimento = 1'b1;
      E_EXECUTA:           aciona_movimento = 1'b1;
      E_CONTA_EXEC:        r_conta_movimento = 1'b1;
      E_FIM:               pronto = 1'b1;
      E_ERRO: begin
`ifdef UC_TIMEOUT_EN
        erro = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  assign db_estado = r_estado;

endmodule
